// File: rtl/i2s_mic_capture_if.sv
// rtl/i2s_mic_capture_if.sv - I2S bus and DMA readout bundle for the mic capture block
//
// Groups the I2S bus pins and the DMA-side readout signals.
//   enable      : run (1) / stop (0) the I2S bus, level
//   i2s_sd      : serial data, one bit per stereo pair, asynchronous
//   i2s_bclk    : bit clock driven by the capture block
//   i2s_lrclk   : word select, 0 = left, 1 = right
//   select      : pair select, k in 1..NUM_MIC_PAIRS picks pair k-1
//   mic_data    : held frame {left, right} of the selected pair
//   read_ready  : one-cycle strobe, new frame in the holding registers
//   frame_count : delivered frames, wraps
//   busy        : capture block is warming up or running
// master = capture block side, slave = microphone/DMA/test side.
interface i2s_mic_capture_if #(
  parameter int NUM_MIC_PAIRS = 4
);
  logic                     enable;
  logic [NUM_MIC_PAIRS-1:0] i2s_sd;
  logic                     i2s_bclk;
  logic                     i2s_lrclk;
  logic [2:0]               select;
  logic [31:0]              mic_data;
  logic                     read_ready;
  logic [15:0]              frame_count;
  logic                     busy;

  modport master (
    input  enable, i2s_sd, select,
    output i2s_bclk, i2s_lrclk, mic_data, read_ready, frame_count, busy
  );

  modport slave (
    output enable, i2s_sd, select,
    input  i2s_bclk, i2s_lrclk, mic_data, read_ready, frame_count, busy
  );
endinterface

// File: rtl/i2s_mic_capture.sv
// rtl/i2s_mic_capture.sv - I2S master capturing 16-bit stereo frames from several mic pairs
//
// Generates BCLK/LRCLK, shifts in one SD line per stereo pair, discards the
// first STARTUP_FRAMES frames after each enable, then copies every completed
// frame into per-pair holding registers and strobes read_ready.
// Ports:
//   CLK   : system clock
//   RESET : synchronous, active-high reset
//   bus   : i2s_mic_capture_if.master (I2S pins, enable, readout mux, status)
module i2s_mic_capture #(
  parameter int NUM_MIC_PAIRS  = 4,
  parameter int BCLK_DIV       = 8,
  parameter int STARTUP_FRAMES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  i2s_mic_capture_if.master      bus
);

  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int WARM_W = $clog2(STARTUP_FRAMES + 1) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN
  } state_t;

  state_t                   state_q, state_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic                     bclk_q, bclk_d;
  logic [5:0]               bit_q, bit_d;
  logic [WARM_W-1:0]        warm_q, warm_d;
  logic [NUM_MIC_PAIRS-1:0] sync1_q, sync1_d;
  logic [NUM_MIC_PAIRS-1:0] sync2_q, sync2_d;
  logic [15:0]              left_q  [NUM_MIC_PAIRS];
  logic [15:0]              left_d  [NUM_MIC_PAIRS];
  logic [15:0]              right_q [NUM_MIC_PAIRS];
  logic [15:0]              right_d [NUM_MIC_PAIRS];
  logic [31:0]              hold_q  [NUM_MIC_PAIRS];
  logic [31:0]              hold_d  [NUM_MIC_PAIRS];
  logic                     read_ready_q, read_ready_d;
  logic [15:0]              frame_count_q, frame_count_d;
  logic                     busy_q, busy_d;

  logic                     fall;
  logic [4:0]               slot;
  logic                     in_sample;
  logic [31:0]              mic_data;

  // Position within the current 32-bit slot; bit 0 is the I2S delay bit.
  assign slot      = bit_q[4:0];
  assign in_sample = (slot >= 5'd1) && (slot <= 5'd16);

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    bclk_d        = bclk_q;
    bit_d         = bit_q;
    warm_d        = warm_q;
    sync1_d       = bus.i2s_sd;
    sync2_d       = sync1_q;
    left_d        = left_q;
    right_d       = right_q;
    hold_d        = hold_q;
    read_ready_d  = 1'b0;
    frame_count_d = frame_count_q;
    busy_d        = busy_q;
    fall          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        bclk_d = 1'b0;
        bit_d  = '0;
        if (bus.enable) begin
          state_d = ST_WARMUP;
          warm_d  = '0;
          busy_d  = 1'b1;
        end
      end

      default: begin
        if (div_q == DIV_W'(BCLK_DIV - 1)) begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          fall   = bclk_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end

        if (fall) begin
          if (in_sample) begin
            for (int k = 0; k < NUM_MIC_PAIRS; k++) begin
              if (bit_q[5]) right_d[k] = {right_q[k][14:0], sync2_q[k]};
              else          left_d[k]  = {left_q[k][14:0],  sync2_q[k]};
            end
          end
          bit_d = bit_q + 6'd1;

          // Falling edge closing bit 63 completes the frame.
          if (bit_q == 6'd63) begin
            if (state_q == ST_RUN) begin
              for (int k = 0; k < NUM_MIC_PAIRS; k++) begin
                hold_d[k] = {left_q[k], right_q[k]};
              end
              read_ready_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
            end else begin
              warm_d = warm_q + WARM_W'(1);
            end
          end
        end

        // With STARTUP_FRAMES = 0 this leaves WARMUP one cycle after entry,
        // long before the first frame can complete.
        if ((state_q == ST_WARMUP) && (warm_q >= WARM_W'(STARTUP_FRAMES))) begin
          state_d = ST_RUN;
        end
      end
    endcase

    // Stop overrides everything: the partial frame is dropped, but the
    // holding registers and frame counter keep their contents.
    if (!bus.enable) begin
      state_d       = ST_IDLE;
      div_d         = '0;
      bclk_d        = 1'b0;
      bit_d         = '0;
      read_ready_d  = 1'b0;
      busy_d        = 1'b0;
      hold_d        = hold_q;
      frame_count_d = frame_count_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      bclk_q        <= 1'b0;
      bit_q         <= '0;
      warm_q        <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      for (int k = 0; k < NUM_MIC_PAIRS; k++) begin
        left_q[k]  <= '0;
        right_q[k] <= '0;
        hold_q[k]  <= '0;
      end
      read_ready_q  <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bclk_q        <= bclk_d;
      bit_q         <= bit_d;
      warm_q        <= warm_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      left_q        <= left_d;
      right_q       <= right_d;
      hold_q        <= hold_d;
      read_ready_q  <= read_ready_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
    end
  end

  // Zero-latency readout mux; out-of-range selects read as zero.
  always_comb begin
    mic_data = 32'h0;
    for (int k = 0; k < NUM_MIC_PAIRS; k++) begin
      if (bus.select == 3'(k + 1)) mic_data = hold_q[k];
    end
  end

  assign bus.mic_data    = mic_data;
  assign bus.i2s_bclk    = bclk_q;
  assign bus.i2s_lrclk   = bit_q[5];
  assign bus.read_ready  = read_ready_q;
  assign bus.frame_count = frame_count_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_i2s_mic_capture.sv
// tb/tb_i2s_mic_capture.sv - directed self-checking bench for i2s_mic_capture
module tb_i2s_mic_capture;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  // dut_a: default parameters; dut_b: no warmup frames.
  i2s_mic_capture_if #(.NUM_MIC_PAIRS(4)) ifa ();
  i2s_mic_capture_if #(.NUM_MIC_PAIRS(4)) ifb ();

  i2s_mic_capture #(.NUM_MIC_PAIRS(4), .BCLK_DIV(8), .STARTUP_FRAMES(2))
    dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa.master));
  i2s_mic_capture #(.NUM_MIC_PAIRS(4), .BCLK_DIV(8), .STARTUP_FRAMES(0))
    dut_b (.CLK(CLK), .RESET(RESET), .bus(ifb.master));

  // Strobe monitors: count high cycles and remember strobe times.
  int rr_a = 0, last_a = 0, prev_a = 0;
  int rr_b = 0, last_b = 0, prev_b = 0;
  always @(negedge CLK) begin
    if (ifa.read_ready === 1'b1) begin rr_a++; prev_a = last_a; last_a = cyc; end
    if (ifb.read_ready === 1'b1) begin rr_b++; prev_b = last_b; last_b = cyc; end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Sample word for frame seed f, pair p, channel ch (0 left, 1 right).
  function automatic logic [15:0] pat(int f, int p, int ch);
    return (ch != 0 ? 16'h1234 : 16'hA5C3) + 16'(f * 257) + 16'(p * 4112);
  endfunction

  function automatic logic [31:0] frame_word(int f, int p);
    return {pat(f, p, 0), pat(f, p, 1)};
  endfunction

  task automatic set_en(int which, logic v);
    if (which == 0) ifa.enable = v; else ifb.enable = v;
  endtask

  task automatic set_sd(int which, int f, int b);
    logic [3:0]  v;
    logic [15:0] w;
    int s;
    s = b % 32;
    for (int p = 0; p < 4; p++) begin
      if (s >= 1 && s <= 16) begin
        w = pat(f, p, b / 32);
        v[p] = w[16 - s];
      end else begin
        v[p] = 1'b1;
      end
    end
    if (which == 0) ifa.i2s_sd = v; else ifb.i2s_sd = v;
  endtask

  task automatic wait_fall(int which, output bit ok);
    logic prev, cur;
    prev = (which == 0) ? ifa.i2s_bclk : ifb.i2s_bclk;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      cur = (which == 0) ? ifa.i2s_bclk : ifb.i2s_bclk;
      if (prev === 1'b1 && cur === 1'b0) begin ok = 1'b1; break; end
      prev = cur;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL bclk_fall: got no falling edge in 40 cycles, required one");
    end
  endtask

  // Drives n frames (seeds f0..f0+n-1) bit by bit; on the last frame,
  // drops enable at abort_bit instead of completing it (-1 = never).
  task automatic drive_frames(int which, int f0, int n, int abort_bit);
    bit ok;
    for (int f = 0; f < n; f++) begin
      for (int b = 0; b < 64; b++) begin
        set_sd(which, f0 + f, b);
        if (f == n - 1 && b == abort_bit) begin set_en(which, 1'b0); return; end
        wait_fall(which, ok);
        if (!ok) return;
      end
    end
  endtask

  task automatic test_reset();
    logic bad;
    ifa.enable = 1'b0; ifb.enable = 1'b0;
    ifa.i2s_sd = '1;   ifb.i2s_sd = '1;
    ifa.select = 3'd0; ifb.select = 3'd0;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RESET = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if ((ifa.i2s_bclk | ifa.i2s_lrclk | ifb.i2s_bclk | ifb.i2s_lrclk) !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL reset_clocks: got activity %b, want 0", bad); end
    checks++; if (rr_a + rr_b != 0) begin errors++; $display("FAIL reset_strobe: got %0d strobes, want 0", rr_a + rr_b); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", ifa.busy); end
    checks++; if (ifa.frame_count !== 16'h0) begin errors++; $display("FAIL reset_fc: got %h, want 0000", ifa.frame_count); end
    for (int s = 0; s < 8; s++) begin
      ifa.select = 3'(s);
      #1;
      checks++;
      if (ifa.mic_data !== 32'h0) begin errors++; $display("FAIL reset_mux sel=%0d: got %h, want 00000000", s, ifa.mic_data); end
    end
    ifa.select = 3'd1;
  endtask

  task automatic test_frame_capture();
    ifb.select = 3'd1;
    set_en(1, 1'b1);
    drive_frames(1, 0, 1, -1);
    set_en(1, 1'b0);
    repeat (3) @(negedge CLK);
    checks++; if (rr_b != 1) begin errors++; $display("FAIL cap_strobe: got %0d strobe cycles, want 1", rr_b); end
    checks++; if (ifb.mic_data !== 32'hA5C31234) begin errors++; $display("FAIL cap_data: got %h, want a5c31234", ifb.mic_data); end
    checks++; if (ifb.frame_count !== 16'h0001) begin errors++; $display("FAIL cap_fc: got %h, want 0001", ifb.frame_count); end
  endtask

  task automatic test_multi_pair();
    logic [31:0] exp;
    set_en(1, 1'b1);
    drive_frames(1, 5, 1, -1);
    set_en(1, 1'b0);
    repeat (2) @(negedge CLK);
    checks++; if (ifb.frame_count !== 16'h0002) begin errors++; $display("FAIL mp_fc: got %h, want 0002", ifb.frame_count); end
    for (int s = 0; s < 8; s++) begin
      @(negedge CLK) ifb.select = 3'(s);
      #1;
      exp = (s >= 1 && s <= 4) ? frame_word(5, s - 1) : 32'h0;
      checks++;
      if (ifb.mic_data !== exp) begin errors++; $display("FAIL mux sel=%0d: got %h, want %h", s, ifb.mic_data, exp); end
    end
  endtask

  task automatic test_warmup();
    ifa.select = 3'd1;
    set_en(0, 1'b1);
    drive_frames(0, 10, 2, -1);
    @(negedge CLK);
    checks++; if (rr_a != 0) begin errors++; $display("FAIL warm_nostrobe: got %0d strobe cycles, want 0", rr_a); end
    drive_frames(0, 12, 1, -1);
    @(negedge CLK);
    checks++; if (rr_a != 1) begin errors++; $display("FAIL warm_first: got %0d strobe cycles, want 1", rr_a); end
    checks++; if (ifa.mic_data !== frame_word(12, 0)) begin errors++; $display("FAIL warm_data: got %h, want %h", ifa.mic_data, frame_word(12, 0)); end
    drive_frames(0, 13, 1, -1);
    @(negedge CLK);
    checks++; if (rr_a != 2) begin errors++; $display("FAIL warm_second: got %0d strobe cycles, want 2", rr_a); end
    checks++; if (last_a - prev_a != 1024) begin errors++; $display("FAIL warm_period: got %0d cycles, want 1024", last_a - prev_a); end
    checks++; if (ifa.mic_data !== frame_word(13, 0)) begin errors++; $display("FAIL warm_data2: got %h, want %h", ifa.mic_data, frame_word(13, 0)); end
  endtask

  task automatic test_abort();
    drive_frames(0, 14, 1, 40);
    @(negedge CLK);
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, want 0", ifa.busy); end
    repeat (4) @(negedge CLK);
    checks++; if (ifa.i2s_bclk !== 1'b0) begin errors++; $display("FAIL abort_bclk: got %b, want 0", ifa.i2s_bclk); end
    checks++; if (rr_a != 2) begin errors++; $display("FAIL abort_strobe: got %0d strobe cycles, want 2", rr_a); end
    checks++; if (ifa.mic_data !== frame_word(13, 0)) begin errors++; $display("FAIL abort_hold1: got %h, want %h", ifa.mic_data, frame_word(13, 0)); end
    ifa.select = 3'd4;
    #1;
    checks++; if (ifa.mic_data !== frame_word(13, 3)) begin errors++; $display("FAIL abort_hold4: got %h, want %h", ifa.mic_data, frame_word(13, 3)); end
    ifa.select = 3'd1;
    set_en(0, 1'b1);
    drive_frames(0, 20, 2, -1);
    @(negedge CLK);
    checks++; if (rr_a != 2) begin errors++; $display("FAIL rewarm_nostrobe: got %0d strobe cycles, want 2", rr_a); end
    drive_frames(0, 22, 1, -1);
    @(negedge CLK);
    set_en(0, 1'b0);
    checks++; if (rr_a != 3) begin errors++; $display("FAIL rewarm_strobe: got %0d strobe cycles, want 3", rr_a); end
    checks++; if (ifa.mic_data !== frame_word(22, 0)) begin errors++; $display("FAIL rewarm_data: got %h, want %h", ifa.mic_data, frame_word(22, 0)); end
    checks++; if (ifa.frame_count !== 16'h0003) begin errors++; $display("FAIL rewarm_fc: got %h, want 0003", ifa.frame_count); end
  endtask

  task automatic test_wrap();
    @(negedge CLK);
    force dut_b.frame_count_q = 16'hFFFE;
    repeat (2) @(negedge CLK);
    release dut_b.frame_count_q;
    @(negedge CLK);
    set_en(1, 1'b1);
    drive_frames(1, 30, 1, -1);
    @(negedge CLK);
    checks++; if (ifb.frame_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h, want ffff", ifb.frame_count); end
    drive_frames(1, 31, 1, -1);
    @(negedge CLK);
    set_en(1, 1'b0);
    checks++; if (ifb.frame_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h, want 0000", ifb.frame_count); end
    ifb.select = 3'd2;
    #1;
    checks++; if (ifb.mic_data !== frame_word(31, 1)) begin errors++; $display("FAIL wrap_data: got %h, want %h", ifb.mic_data, frame_word(31, 1)); end
  endtask

  initial begin
    test_reset();
    test_frame_capture();
    test_multi_pair();
    test_warmup();
    test_abort();
    test_wrap();
    repeat (4) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
